// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port synchronous memory between
// instruction fetch (IF) and data load/store (D). Grants are combinational,
// responses come back one cycle later. D has priority over IF.
// Optional fetch-starvation guard: define MEM_ARB_STARVE_GUARD_EN.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned MAX_DSTREAK = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_be,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                busy
);

  localparam int unsigned BE_W     = DATA_W / 8;
  localparam int unsigned STREAK_W = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RESP_IF = 2'd1,
    RESP_D  = 2'd2
  } state_e;

  state_e state_q, state_d;
  logic   force_if;

`ifdef MEM_ARB_STARVE_GUARD_EN
  logic [STREAK_W-1:0] streak_q, streak_d;

  // Count D wins over a waiting fetch; a fetch win or an idle fetch clears it.
  always_comb begin
    streak_d = streak_q;
    if (!if_req || if_gnt) begin
      streak_d = '0;
    end else if (d_gnt) begin
      streak_d = streak_q + STREAK_W'(1);
    end
  end

  // Streak register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      streak_q <= '0;
    end else begin
      streak_q <= streak_d;
    end
  end

  assign force_if = if_req && d_req && (streak_q == STREAK_W'(MAX_DSTREAK));
`else
  logic unused_max_dstreak;
  assign unused_max_dstreak = ^(STREAK_W'(MAX_DSTREAK));
  assign force_if = 1'b0;
`endif

  // One-hot grant: D first unless the guard hands this slot to IF.
  always_comb begin
    if_gnt = 1'b0;
    d_gnt  = 1'b0;
    if (rst) begin
      if (d_req && !force_if) begin
        d_gnt = 1'b1;
      end else if (if_req) begin
        if_gnt = 1'b1;
      end
    end
  end

  // Forward the winner's command; IF is always a full-word read.
  always_comb begin
    mem_en    = if_gnt | d_gnt;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_be    = '0;
    if (d_gnt) begin
      mem_we    = d_we;
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
      mem_be    = d_be;
    end else if (if_gnt) begin
      mem_addr = if_addr;
      mem_be   = {BE_W{1'b1}};
    end
  end

  // Response state register; reset drops any outstanding response.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state follows this cycle's grant.
  always_comb begin
    state_d = IDLE;
    if (if_gnt) begin
      state_d = RESP_IF;
    end else if (d_gnt) begin
      state_d = RESP_D;
    end
  end

  // Response routing decoded from the registered state.
  always_comb begin
    if_rvalid = (state_q == RESP_IF);
    d_rvalid  = (state_q == RESP_D);
    busy      = (state_q != IDLE);
    if_rdata  = mem_rdata;
    d_rdata   = mem_rdata;
  end

endmodule
